branch_predict_unit: RTL and testbench

- Parametrised successor to the single-cycle branch comparator: resolves RV32 branches in EX (EQ/NE/LT/GE/LTU/GEU at XLEN width).
- Adds a 2-bit saturating-counter branch history table (BHT), with optional gshare global-history indexing.
- Fetch reads `predict_taken` combinationally for the current PC.
- EX resolves the branch, flags a mispredict to the hazard/flush logic and trains the BHT on the clock edge.

---
 rtl/branch_predict_unit.sv | 131 +++++++++++++
 tb/tb_branch_predict_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// RV32 branch resolve unit with a 2-bit saturating-counter BHT (bimodal, or gshare when GHIST_BITS > 0).
// Define BRANCH_STATS_EN to add the stat_branches / stat_mispredicts counters.
package control_types_pkg;
  typedef enum logic [2:0] {
    BR_NOP = 3'd0,
    BR_EQ  = 3'd1,
    BR_NE  = 3'd2,
    BR_LT  = 3'd3,
    BR_GE  = 3'd4,
    BR_LTU = 3'd5,
    BR_GEU = 3'd6
  } comp_op_t;
endpackage

module branch_predict_unit
  import control_types_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int GHIST_BITS  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  comp_op_t        comp_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            ex_pred_taken,
  output logic            branch_taken,
  output logic            mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam logic [1:0] CTR_RESET = 2'b01;

  logic [1:0]     bht [BHT_ENTRIES];
  logic [IDX-1:0] ghr_idx;
  logic [IDX-1:0] fidx;
  logic [IDX-1:0] eidx;
  logic           is_br;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    branch_taken = 1'b0;
    case (comp_op)
      BR_EQ:   branch_taken = (operand_a == operand_b);
      BR_NE:   branch_taken = (operand_a != operand_b);
      BR_LT:   branch_taken = ($signed(operand_a) <  $signed(operand_b));
      BR_GE:   branch_taken = ($signed(operand_a) >= $signed(operand_b));
      BR_LTU:  branch_taken = (operand_a <  operand_b);
      BR_GEU:  branch_taken = (operand_a >= operand_b);
      default: branch_taken = 1'b0;
    endcase
  end

  assign is_br = ex_valid && (comp_op != BR_NOP);

  // A non-branch predicted taken still mispredicts so fetch can redirect to PC+4.
  assign mispredict = !rst && ex_valid && (branch_taken != ex_pred_taken);

  generate
    if (GHIST_BITS == 0) begin : g_bimodal
      assign ghr_idx = '0;
    end else begin : g_gshare
      logic [GHIST_BITS-1:0] ghr;
      logic [GHIST_BITS:0]   ghr_shift;

      assign ghr_shift = {ghr, branch_taken};

      // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr <= '0;
        end else if (is_br) begin
          ghr <= ghr_shift[GHIST_BITS-1:0];
        end
      end

      assign ghr_idx = IDX'(ghr);
    end
  endgenerate

  assign fidx = fetch_pc[IDX+1:2] ^ ghr_idx;
  assign eidx = ex_pc[IDX+1:2]    ^ ghr_idx;

  // PC bits outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX+2], fetch_pc[1:0],
                            ex_pc[XLEN-1:IDX+2], ex_pc[1:0]};

  // NOTE: the BHT is a flop array, not an SRAM macro, so it can take the async reset to weak-NT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_RESET;
      end
    end else if (is_br) begin
      if (branch_taken && (bht[eidx] != 2'b11)) begin
        bht[eidx] <= bht[eidx] + 2'd1;
      end else if (!branch_taken && (bht[eidx] != 2'b00)) begin
        bht[eidx] <= bht[eidx] - 2'd1;
      end
    end
  end

  // No bypass: a same-cycle update to fidx shows up on the next cycle.
  assign predict_taken = bht[fidx][1];

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (is_br) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: bimodal instance plus a GHIST_BITS=2 gshare instance.
// Expected values are queued when stimulus is driven and popped when outputs are sampled.
module tb_branch_predict_unit;
  import control_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] fetch_pc, ex_pc, operand_a, operand_b;
  logic        ex_valid, ex_pred_taken;
  comp_op_t    comp_op;
  logic        predict_taken, branch_taken, mispredict;

  logic [31:0] fetch_pc_g, ex_pc_g, operand_a_g, operand_b_g;
  logic        ex_valid_g, ex_pred_taken_g;
  comp_op_t    comp_op_g;
  logic        predict_taken_g, branch_taken_g, mispredict_g;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
  logic [31:0] stat_branches_g, stat_mispredicts_g;
`endif

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .GHIST_BITS(0)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(predict_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .comp_op(comp_op),
    .operand_a(operand_a), .operand_b(operand_b), .ex_pred_taken(ex_pred_taken),
    .branch_taken(branch_taken), .mispredict(mispredict)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .GHIST_BITS(2)) dut_g (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc_g), .predict_taken(predict_taken_g),
    .ex_valid(ex_valid_g), .ex_pc(ex_pc_g), .comp_op(comp_op_g),
    .operand_a(operand_a_g), .operand_b(operand_b_g), .ex_pred_taken(ex_pred_taken_g),
    .branch_taken(branch_taken_g), .mispredict(mispredict_g)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches_g), .stat_mispredicts(stat_mispredicts_g)
`endif
  );

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic pop_check(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    total++;
    if (val_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%0h expected=<none>", observed);
      return;
    end
    tag      = tag_q.pop_front();
    expected = val_q.pop_front();
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_ex(input logic v, input comp_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic pred);
    ex_valid      = v;
    comp_op       = op;
    operand_a     = a;
    operand_b     = b;
    ex_pc         = pc;
    ex_pred_taken = pred;
  endtask

  // One EX cycle on the bimodal instance: drive at negedge, resolve on the next posedge.
  task automatic resolve(input logic v, input comp_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic pred);
    @(negedge clk);
    drive_ex(v, op, a, b, pc, pred);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  comp_op_t    ops   [10];
  logic [31:0] opa   [10];
  logic [31:0] opb   [10];
  logic        preds [10];
  logic        exps  [10];

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ops[0] = BR_LT;  opa[0] = 32'hFFFF_FFFF; opb[0] = 32'd5;          preds[0] = 1'b0; exps[0] = 1'b1;
    ops[1] = BR_LTU; opa[1] = 32'hFFFF_FFFF; opb[1] = 32'd5;          preds[1] = 1'b0; exps[1] = 1'b0;
    ops[2] = BR_GE;  opa[2] = 32'hFFFF_FFFF; opb[2] = 32'd5;          preds[2] = 1'b1; exps[2] = 1'b0;
    ops[3] = BR_GEU; opa[3] = 32'hFFFF_FFFF; opb[3] = 32'd5;          preds[3] = 1'b1; exps[3] = 1'b1;
    ops[4] = BR_EQ;  opa[4] = 32'd100;       opb[4] = 32'd100;        preds[4] = 1'b0; exps[4] = 1'b1;
    ops[5] = BR_NE;  opa[5] = 32'd100;       opb[5] = 32'd100;        preds[5] = 1'b0; exps[5] = 1'b0;
    ops[6] = BR_LT;  opa[6] = 32'h8000_0000; opb[6] = 32'h7FFF_FFFF;  preds[6] = 1'b1; exps[6] = 1'b1;
    ops[7] = BR_LTU; opa[7] = 32'h8000_0000; opb[7] = 32'h7FFF_FFFF;  preds[7] = 1'b1; exps[7] = 1'b0;
    ops[8] = comp_op_t'(3'd7); opa[8] = 32'd1; opb[8] = 32'd1;        preds[8] = 1'b0; exps[8] = 1'b0;
    ops[9] = BR_GE;  opa[9] = 32'd5;         opb[9] = 32'd5;          preds[9] = 1'b1; exps[9] = 1'b1;

    rst = 1'b1;
    drive_ex(1'b0, BR_NOP, 32'd0, 32'd0, 32'd0, 1'b0);
    fetch_pc        = 32'd0;
    fetch_pc_g      = 32'd0;
    ex_valid_g      = 1'b0;
    ex_pc_g         = 32'd0;
    comp_op_g       = BR_NOP;
    operand_a_g     = 32'd0;
    operand_b_g     = 32'd0;
    ex_pred_taken_g = 1'b0;

    // Mispredict is suppressed while reset is held, even for a wrong prediction.
    @(negedge clk);
    drive_ex(1'b1, BR_EQ, 32'd5, 32'd6, 32'h0, 1'b1);
    push("rst_mispredict", 32'd0);
    #1;
    pop_check(mispredict);
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    rst      = 1'b0;

    for (int i = 0; i < 64; i++) begin
      fetch_pc = i * 4;
      push($sformatf("sweep_idx%0d", i), 32'd0);
      #1;
      pop_check(predict_taken);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_ex(1'b1, ops[i], opa[i], opb[i], 32'h20, preds[i]);
      push($sformatf("cmp%0d_taken", i), exps[i]);
      push($sformatf("cmp%0d_mispredict", i), exps[i] ^ preds[i]);
      #1;
      pop_check(branch_taken);
      pop_check(mispredict);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
    end

    // Training at 0x40: fetch of the entry being trained sees the old value in that cycle.
    fetch_pc = 32'h40;
    @(negedge clk);
    drive_ex(1'b1, BR_EQ, 32'd1, 32'd1, 32'h40, 1'b0);
    push("same_cycle_old", 32'd0);
    #1;
    pop_check(predict_taken);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    push("train_t1", 32'd1);
    pop_check(predict_taken);

    for (int i = 0; i < 4; i++) begin
      resolve(1'b1, BR_EQ, 32'd1, 32'd1, 32'h40, 1'b1);
    end
    fetch_pc = 32'h140;
    push("alias_0x140", 32'd1);
    #1;
    pop_check(predict_taken);
    fetch_pc = 32'h40;

    resolve(1'b1, BR_EQ, 32'd1, 32'd2, 32'h40, 1'b1);
    push("sat_nt1", 32'd1);
    pop_check(predict_taken);
    resolve(1'b1, BR_EQ, 32'd1, 32'd2, 32'h40, 1'b1);
    push("sat_nt2", 32'd0);
    pop_check(predict_taken);

    // Bubble carrying a taken branch must neither train nor flag.
    @(negedge clk);
    drive_ex(1'b0, BR_EQ, 32'd1, 32'd1, 32'h40, 1'b0);
    push("bubble_mispredict", 32'd0);
    #1;
    pop_check(mispredict);
    @(posedge clk);
    #1;
    push("bubble_no_train", 32'd0);
    pop_check(predict_taken);

    resolve(1'b1, BR_EQ, 32'd1, 32'd1, 32'h40, 1'b0);
    push("retrain_t", 32'd1);
    pop_check(predict_taken);

    @(negedge clk);
    drive_ex(1'b1, BR_NOP, 32'd1, 32'd2, 32'h40, 1'b1);
    push("nop_taken", 32'd0);
    push("nop_mispredict", 32'd1);
    #1;
    pop_check(branch_taken);
    pop_check(mispredict);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    push("nop_no_train", 32'd1);
    pop_check(predict_taken);

    resolve(1'b0, BR_EQ, 32'd1, 32'd2, 32'h40, 1'b1);
    push("bubble_nt_no_train", 32'd1);
    pop_check(predict_taken);

    // Gshare: alternating T/NT at one PC lands in distinct entries once history fills.
    for (int k = 0; k < 10; k++) begin
      logic outcome, exp_pred, exp_misp;
      outcome  = (k % 2 == 0);
      exp_pred = (k >= 4) ? outcome : 1'b0;
      exp_misp = (k < 4) ? outcome : 1'b0;
      @(negedge clk);
      ex_valid_g      = 1'b1;
      ex_pc_g         = 32'h80;
      fetch_pc_g      = 32'h80;
      comp_op_g       = BR_EQ;
      operand_a_g     = 32'd1;
      operand_b_g     = outcome ? 32'd1 : 32'd2;
      ex_pred_taken_g = exp_pred;
      push($sformatf("gs%0d_predict", k), exp_pred);
      push($sformatf("gs%0d_mispredict", k), exp_misp);
      #1;
      pop_check(predict_taken_g);
      pop_check(mispredict_g);
      @(posedge clk);
      #1;
      ex_valid_g = 1'b0;
    end

    // Async reset mid-cycle clears counters without waiting for an edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push("async_rst_predict", 32'd0);
    pop_check(predict_taken);
`ifdef BRANCH_STATS_EN
    push("async_rst_stat_br", 32'd0);
    push("async_rst_stat_mp", 32'd0);
    pop_check(stat_branches);
    pop_check(stat_mispredicts);
`endif
    @(negedge clk);
    rst = 1'b0;

`ifdef BRANCH_STATS_EN
    for (int j = 0; j < 12; j++) begin
      logic v, p;
      v = !(j == 3 || j == 8);
      p = !(j == 1 || j == 5 || j == 10);
      resolve(v, BR_EQ, 32'd1, 32'd1, 32'h0, p);
    end
    push("stat_branches", 32'd10);
    push("stat_mispredicts", 32'd3);
    pop_check(stat_branches);
    pop_check(stat_mispredicts);

    @(negedge clk);
    force dut.stat_branches    = 32'hFFFF_FFFF;
    force dut.stat_mispredicts = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches;
    release dut.stat_mispredicts;
    resolve(1'b1, BR_EQ, 32'd1, 32'd1, 32'h0, 1'b0);
    push("wrap_stat_branches", 32'd0);
    push("wrap_stat_mispredicts", 32'd0);
    pop_check(stat_branches);
    pop_check(stat_mispredicts);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
